// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM logic-port arbiter.
// Optional round-robin selection is enabled by defining SDRAM_ARB_RR_EN.
package sdram_arb_pkg;

  localparam int ADDR_W = 24;

  localparam logic [1:0] PORT_NONE   = 2'd0;
  localparam logic [1:0] PORT_IFETCH = 2'd1;
  localparam logic [1:0] PORT_DATA   = 2'd2;
  localparam logic [1:0] PORT_DMA    = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  // Requester index (1..3) to its bit in the 3-bit request/ready vectors.
  function automatic logic [2:0] port_onehot(input logic [1:0] port);
    case (port)
      PORT_IFETCH: return 3'b001;
      PORT_DATA:   return 3'b010;
      PORT_DMA:    return 3'b100;
      default:     return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection for the SDRAM port arbiter.
// SDRAM_ARB_RR_EN defined: round-robin starting after last_grant (3 wraps to 1).
// Undefined: fixed priority 1 > 2 > 3, last_grant ignored.
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] mask,
  input  logic [1:0] last_grant,
  output logic [1:0] winner
);

  logic [2:0] elig;

  assign elig = req & ~mask;

`ifdef SDRAM_ARB_RR_EN
  // First eligible requester in the order a, b, c.
  function automatic logic [1:0] first_of(input logic [2:0] e, input logic [1:0] a,
                                          input logic [1:0] b, input logic [1:0] c);
    if (e[a - 2'd1]) return a;
    if (e[b - 2'd1]) return b;
    if (e[c - 2'd1]) return c;
    return PORT_NONE;
  endfunction

  // Rotate the search so it begins just after the previous owner.
  always_comb begin
    winner = PORT_NONE;
    case (last_grant)
      PORT_IFETCH: winner = first_of(elig, PORT_DATA, PORT_DMA, PORT_IFETCH);
      PORT_DATA:   winner = first_of(elig, PORT_DMA, PORT_IFETCH, PORT_DATA);
      default:     winner = first_of(elig, PORT_IFETCH, PORT_DATA, PORT_DMA);
    endcase
  end
`else
  logic unused_last_grant;

  assign unused_last_grant = ^last_grant;

  // Fixed priority: instruction fetch, then data, then DMA.
  always_comb begin
    winner = PORT_NONE;
    if (elig[0])      winner = PORT_IFETCH;
    else if (elig[1]) winner = PORT_DATA;
    else if (elig[2]) winner = PORT_DMA;
  end
`endif

endmodule

// File: rtl/sdram_port_arbiter.sv
// Three-requester arbiter in front of the SDRAM controller logic-side port.
// Define SDRAM_ARB_RR_EN for round-robin selection (default: fixed 1 > 2 > 3).
//
// state | meaning
// IDLE  | no transaction; grant a pending request and load mem_* outputs
// CMD   | one-cycle mem_rd/mem_wr strobe to the controller
// WAIT  | strobe low, mem_* held; wait for mem_ready, run timeout counter
// DONE  | req_ready to owner; chain straight into next grant if one is pending
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
)
(
  input  logic              clk,
  input  logic              resetn,
  input  logic [2:0]        req_rd,
  input  logic [2:0]        req_wr,
  input  logic [ADDR_W-1:0] req_addr  [1:3],
  input  logic [31:0]       req_wdata [1:3],
  input  logic [3:0]        req_be    [1:3],
  output logic [2:0]        req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic [1:0]        mem_port,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ready,
  output logic [1:0]        grant,
  output logic              err_timeout
);

  arb_state_t state;
  logic [7:0] tmo_cnt;
  logic [2:0] pick_mask;
  logic [1:0] pick_last;
  logic [1:0] winner;

`ifdef SDRAM_ARB_RR_EN
  logic [1:0] last_grant;

  assign pick_last = last_grant;
`else
  assign pick_last = PORT_DMA;
`endif

  // The finishing owner still shows its request during DONE, so hide it there.
  assign pick_mask = (state == DONE) ? port_onehot(grant) : 3'b000;

  sdram_arb_pick u_pick (
    .req        (req_rd | req_wr),
    .mask       (pick_mask),
    .last_grant (pick_last),
    .winner     (winner)
  );

  // Arbitration FSM with registered controller-side outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      req_ready   <= 3'b000;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      mem_port    <= PORT_NONE;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      grant       <= PORT_NONE;
      err_timeout <= 1'b0;
      tmo_cnt     <= '0;
`ifdef SDRAM_ARB_RR_EN
      last_grant  <= PORT_DMA;
`endif
    end else begin
      req_ready <= 3'b000;
      case (state)
        IDLE, DONE: begin
          if (winner != PORT_NONE) begin
            mem_addr   <= req_addr[winner];
            mem_wdata  <= req_wdata[winner];
            mem_be     <= req_be[winner];
            mem_port   <= winner;
            grant      <= winner;
            // Write wins when a requester raises both strobes.
            mem_wr     <= req_wr[winner - 2'd1];
            mem_rd     <= ~req_wr[winner - 2'd1];
`ifdef SDRAM_ARB_RR_EN
            last_grant <= winner;
`endif
            state      <= CMD;
          end else begin
            grant <= PORT_NONE;
            state <= IDLE;
          end
        end
        CMD: begin
          mem_rd  <= 1'b0;
          mem_wr  <= 1'b0;
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
          // Flag only; the controller is still expected to finish eventually.
          if ((TIMEOUT != 8'd0) && (tmo_cnt + 8'd1 == TIMEOUT)) err_timeout <= 1'b1;
          if (mem_ready) begin
            req_ready <= port_onehot(grant);
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter; expectations follow SDRAM_ARB_RR_EN.
module tb_sdram_port_arbiter;

  localparam logic [7:0] TMO = 8'd4;

  typedef struct packed {
    logic [1:0]  port;
    logic        wr;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  req_rd = 3'b000;
  logic [2:0]  req_wr = 3'b000;
  logic [23:0] req_addr  [1:3];
  logic [31:0] req_wdata [1:3];
  logic [3:0]  req_be    [1:3];
  logic [2:0]  req_ready;
  logic [23:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [1:0]  mem_port;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_ready = 1'b0;
  logic [1:0]  grant;
  logic        err_timeout;

  sdram_port_arbiter #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_be      (req_be),
    .req_ready   (req_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_port    (mem_port),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_ready   (mem_ready),
    .grant       (grant),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  cmd_t        exp_q[$];
  int          rem [1:3];
  int          ph = 0;
  int          wcount = 0;
  int          ready_delay = 1;
  int          cmd_cnt = 0;
  int          raise2_at = -1;
  int          tx_in_test = 0;
  logic [1:0]  cur = 2'd0;
  logic [61:0] held = '0;
  bit          exp_err = 0;
  bit          expect_b2b = 0;
  bit          last_done = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, 64'({req_ready, mem_addr, mem_be, mem_port, mem_rd, mem_wr, grant, err_timeout}), 64'(0));
    chk({tag, "_b"}, 64'(mem_wdata), 64'(0));
  endtask

  task automatic set_req(input int p, input bit rd, input bit wr, input logic [23:0] a,
                         input logic [31:0] d, input logic [3:0] b, input int cnt, input bit now);
    req_addr[p]  = a;
    req_wdata[p] = d;
    req_be[p]    = b;
    rem[p]       = cnt;
    if (now) begin
      req_rd[p-1] = rd;
      req_wr[p-1] = wr;
    end
  endtask

  task automatic expect_cmd(input int p, input bit wr);
    cmd_t e;
    e.port  = 2'(p);
    e.wr    = wr;
    e.addr  = req_addr[p];
    e.wdata = req_wdata[p];
    e.be    = req_be[p];
    exp_q.push_back(e);
  endtask

  // One clock of bench activity: controller model, requester model, scoreboard.
  task automatic step();
    cmd_t        e;
    logic [61:0] now_hold;
    bit          was_done;
    @(negedge clk);
    was_done = 0;
    now_hold = {mem_addr, mem_be, mem_port, mem_wdata};
    chk("err_timeout", 64'(err_timeout), 64'(exp_err));
    if (ph == 2) begin
      was_done  = 1;
      mem_ready = 1'b0;
      chk("ready_pulse", 64'(req_ready), 64'(3'b001 << (int'(cur) - 1)));
      chk("done_hold", 64'(now_hold), 64'(held));
      rem[cur] = rem[cur] - 1;
      if (rem[cur] == 0) begin
        req_rd[cur-1] = 1'b0;
        req_wr[cur-1] = 1'b0;
      end
      ph = 0;
    end else begin
      chk("ready_quiet", 64'(req_ready), 64'(0));
      if (mem_rd || mem_wr) begin
        chk("cmd_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("cmd_port", 64'(mem_port), 64'(e.port));
          chk("cmd_grant", 64'(grant), 64'(e.port));
          chk("cmd_addr", 64'(mem_addr), 64'(e.addr));
          chk("cmd_be", 64'(mem_be), 64'(e.be));
          chk("cmd_wr", 64'(mem_wr), 64'(e.wr));
          chk("cmd_rd", 64'(mem_rd), 64'(!e.wr));
          if (e.wr) chk("cmd_wdata", 64'(mem_wdata), 64'(e.wdata));
          if (expect_b2b && tx_in_test > 0) chk("back_to_back", 64'(last_done), 64'(1));
          tx_in_test++;
          cmd_cnt++;
          if (cmd_cnt == raise2_at) req_rd[1] = 1'b1;
          cur    = e.port;
          held   = now_hold;
          wcount = 0;
          ph     = 1;
        end
      end else if (ph == 1) begin
        wcount++;
        chk("wait_hold", 64'(now_hold), 64'(held));
        chk("wait_grant", 64'(grant), 64'(cur));
        if (wcount == ready_delay) begin
          mem_ready = 1'b1;
          ph = 2;
        end
        if (wcount == int'(TMO)) exp_err = 1;
      end else begin
        chk("idle_grant", 64'(grant), 64'(0));
      end
    end
    last_done = was_done;
  endtask

  task automatic run_until_idle(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || ph != 0 || req_rd != 3'b000 || req_wr != 3'b000) && n < max) begin
      step();
      n++;
    end
    chk("drain_bound", 64'(n < max), 64'(1));
    repeat (3) step();
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    mem_ready = 1'b0;
    req_rd    = 3'b000;
    req_wr    = 3'b000;
    ph        = 0;
    exp_q.delete();
    exp_err   = 0;
    last_done = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset_outputs");
    resetn = 1'b1;
  endtask

  task automatic start_test(input int delay, input bit b2b);
    ready_delay = delay;
    expect_b2b  = b2b;
    tx_in_test  = 0;
    cmd_cnt     = 0;
    raise2_at   = -1;
  endtask

  initial begin
    int n;
    for (int i = 1; i <= 3; i++) begin
      req_addr[i] = '0; req_wdata[i] = '0; req_be[i] = '0; rem[i] = 0;
    end

    do_reset();

    // Single read, controller ready in the second WAIT cycle.
    start_test(2, 0);
    set_req(1, 1, 0, 24'h000100, 32'h0, 4'hF, 1, 1);
    expect_cmd(1, 0);
    run_until_idle(50);

    // All three read in the same cycle: 1, 2, 3 back to back.
    do_reset();
    start_test(1, 1);
    set_req(1, 1, 0, 24'h000200, 32'h0, 4'hF, 1, 1);
    set_req(2, 1, 0, 24'h000300, 32'h0, 4'h3, 1, 1);
    set_req(3, 1, 0, 24'h000400, 32'h0, 4'hC, 1, 1);
    expect_cmd(1, 0);
    expect_cmd(2, 0);
    expect_cmd(3, 0);
    run_until_idle(50);

    // Requesters 1 and 3 held, requester 2 raised during the third command.
    do_reset();
    start_test(1, 0);
    raise2_at = 3;
    set_req(1, 1, 0, 24'h001000, 32'h0, 4'hF, 3, 1);
    set_req(2, 1, 0, 24'h002000, 32'h0, 4'hF, 1, 0);
    set_req(3, 1, 0, 24'h003000, 32'h0, 4'hF, 3, 1);
`ifdef SDRAM_ARB_RR_EN
    expect_cmd(1, 0); expect_cmd(3, 0); expect_cmd(1, 0); expect_cmd(2, 0);
    expect_cmd(3, 0); expect_cmd(1, 0); expect_cmd(3, 0);
`else
    expect_cmd(1, 0); expect_cmd(3, 0); expect_cmd(1, 0); expect_cmd(2, 0);
    expect_cmd(1, 0); expect_cmd(3, 0); expect_cmd(3, 0);
`endif
    run_until_idle(100);

    // Write with a slow controller; outputs held through WAIT, timeout flag rises.
    start_test(5, 0);
    set_req(2, 0, 1, 24'h0ABCDE, 32'hAABBCCDD, 4'b0100, 1, 1);
    expect_cmd(2, 1);
    run_until_idle(50);
    chk("err_after_write", 64'(err_timeout), 64'(1));

    // Read and write both raised on one requester is a write.
    start_test(1, 0);
    set_req(1, 1, 1, 24'h00F00D, 32'h12345678, 4'b1001, 1, 1);
    expect_cmd(1, 1);
    run_until_idle(50);

    // Timeout from a clean reset: ready withheld for 10 WAIT cycles.
    do_reset();
    start_test(10, 0);
    set_req(3, 1, 0, 24'h777777, 32'h0, 4'hF, 1, 1);
    expect_cmd(3, 0);
    run_until_idle(60);
    chk("err_sticky", 64'(err_timeout), 64'(1));

    // Reset in the middle of WAIT, then the held request is served again.
    do_reset();
    start_test(50, 0);
    set_req(1, 1, 0, 24'h055AA0, 32'h0, 4'h5, 1, 1);
    expect_cmd(1, 0);
    n = 0;
    while (!(ph == 1 && wcount == 3) && n < 30) begin
      step();
      n++;
    end
    chk("reach_wait", 64'(n < 30), 64'(1));
    #2 resetn = 1'b0;
    #1 chk_zero("async_reset");
    ph        = 0;
    mem_ready = 1'b0;
    exp_q.delete();
    exp_err   = 0;
    last_done = 0;
    @(negedge clk);
    resetn = 1'b1;
    start_test(2, 0);
    expect_cmd(1, 0);
    run_until_idle(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Shares the single 32-bit logic-side port of the SDRAM controller (cartridge ROM, EWRAM, backup SRAM/flash) among three requesters: 1 = CPU instruction fetch, 2 = CPU data, 3 = DMA. The arbiter does three things:
- Selects one request at a time.
- Drives the controller's address, data, byte-enable and port-tag inputs.
- Returns a completion pulse to the winning requester once that requester's read buffer (controller cpu_rdata[n]) holds valid data.

It sits between the CPU/DMA bus logic and the SDRAM controller.

Parameters:
TIMEOUT, 255, cycles in WAIT before err_timeout is set (8-bit counter; 0 disables the check).

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
req_rd  in  3  per-requester read request, bit i-1 = requester i; held until its req_ready
req_wr  in  3  per-requester write request; rd and wr are never both high on one requester
req_addr[1:3]  in  24 each  word address [25:2]
req_wdata[1:3]  in  32 each  write data
req_be[1:3]  in  4 each  byte enables
req_ready  out  3  one-cycle completion pulse per requester
mem_addr  out  24  to controller cpu_addr
mem_wdata  out  32  to controller cpu_wdata
mem_be  out  4  to controller cpu_be
mem_port  out  2  to controller cpu_port (1..3, never 0)
mem_rd  out  1  to controller cpu_rd
mem_wr  out  1  to controller cpu_wr
mem_ready  in  1  from controller cpu_ready
grant  out  2  current owner (0 = none), for debug
err_timeout  out  1  sticky; cleared only by reset

Behaviour:
Reset (resetn low, asynchronous):
- State returns to IDLE; all outputs 0.
- A transaction in flight is dropped; no req_ready is issued for it.

State IDLE:
- If any req_rd|req_wr bit is set, pick a winner (priority below).
- Register the winner's addr, wdata, be and port into the mem_* outputs; grant = winner.
- Next state CMD.

State CMD (exactly 1 cycle):
- mem_rd or mem_wr is high, matching the winner's request type.
- Next state WAIT.

State WAIT:
- mem_rd and mem_wr are low; mem_addr, mem_be, mem_port and mem_wdata are held stable, because the controller re-samples them after the command cycle.
- When mem_ready = 1, go to DONE.
- The timeout counter increments every WAIT cycle. If it reaches TIMEOUT, err_timeout is set; the arbiter keeps waiting and does not abort.

State DONE (1 cycle):
- req_ready[winner] = 1. This is one cycle after mem_ready, so the upper half of a 32-bit read is already in the buffer.
- mem_* outputs are still held.
- If another request is pending, take the IDLE selection action and go directly to CMD (back-to-back, no idle gap). Otherwise go to IDLE with grant = 0.
- The finishing requester's request bit is masked for the DONE cycle, because its rd/wr is still visible that cycle.

Timing:
- Minimum access-to-ready latency: 3 cycles (IDLE→CMD→WAIT→DONE, with mem_ready arriving in the first WAIT cycle).
- Throughput: one access every 3 cycles under back-to-back load.

Priority without the optional feature: fixed, 1 > 2 > 3.

Illegal inputs:
- A requester dropping its request mid-transaction has no effect; the transaction completes and req_ready still pulses.
- req_rd and req_wr both high on one requester is treated as a write.

Simultaneous events: a new request arriving in the same cycle as mem_ready is not considered until DONE.

Optional Feature:
Macro SDRAM_ARB_RR_EN.
- Defined: round-robin. A 2-bit last_grant register, reset to 3. The search starts at last_grant+1 and wraps 3→1. last_grant updates on each grant.
- Undefined: fixed priority 1 > 2 > 3; no last_grant register.

Decomposition:
- Shared package sdram_arb_pkg holds:
  - state enum {IDLE, CMD, WAIT, DONE}
  - port ID constants PORT_IFETCH = 1, PORT_DATA = 2, PORT_DMA = 3
  - ADDR_W = 24
- One natural sub-module: sdram_arb_pick. It is combinational: inputs are the request vector, mask and last_grant; outputs are winner index (0 = none).

Test Plan:
- Single read: req_rd[1], addr 0x000100, be 4'hF; mem_ready in the 2nd WAIT cycle → mem_rd high for exactly 1 cycle, mem_port = 1, req_ready[1] one cycle after mem_ready, no other req_ready.
- Contention, fixed priority: req_rd on all three in the same cycle → grant order 1, 2, 3, each back-to-back (DONE→CMD), and each requester receives exactly one pulse.
- Round robin (SDRAM_ARB_RR_EN): requesters 1 and 3 held continuously → grants alternate 1, 3, 1, 3; requester 2 raised later is served before the next grant to 1.
- Write hold: req_wr[2], be 4'b0100, wdata 0xAABBCCDD; controller ready delayed 5 cycles → mem_addr, mem_be and mem_wdata are unchanged throughout WAIT, and mem_wr is high only in CMD.
- Timeout: TIMEOUT = 4, mem_ready withheld 10 cycles → err_timeout rises after the 4th WAIT cycle and stays set; req_ready still arrives after mem_ready.
- Reset mid-WAIT: resetn low during WAIT → all outputs 0 immediately; after release, a pending request is granted again from IDLE with mem_rd pulsed once.
